seq_divider: RTL and testbench

- Iterative signed divider; the inverse companion of the team's registered array multiplier.
- Divides a WIDTH_N-bit two's-complement dividend (for example, a multiplier product) by a WIDTH_D-bit two's-complement divisor.
- Produces one quotient bit per clock using a restoring shift-subtract on magnitudes, then applies sign correction.
- Used where a product must be scaled back down, or checked by round trip, without a combinational divide array.

---
 rtl/seq_divider.sv | 152 +++++++++++++++
 tb/tb_seq_divider.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: iterative signed divider (restoring shift-subtract on magnitudes).
// Produces one quotient bit per clock and applies sign correction on the final
// iteration. Divide-by-zero skips the iterations and reports a flag.
module seq_divider #(
    parameter int WIDTH_N = 18,
    parameter int WIDTH_D = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               data_valid,
    output logic               ready,
    input  logic [WIDTH_N-1:0] dividend,
    input  logic [WIDTH_D-1:0] divisor,
    output logic [WIDTH_N-1:0] quotient,
    output logic [WIDTH_D-1:0] remainder,
    output logic               out_valid,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int CW = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      count;
    logic [WIDTH_N-1:0] work;
    logic [WIDTH_D:0]   dsr_mag;
    logic [WIDTH_D:0]   prem;
    logic               neg_q;
    logic               neg_r;
    logic               ovf_pending;

    logic               divisor_zero;
    logic               is_ovf;
    logic [WIDTH_N-1:0] dividend_mag;
    logic [WIDTH_D:0]   divisor_ext;
    logic [WIDTH_D:0]   divisor_mag;
    logic [WIDTH_D:0]   shifted;
    logic               fits;
    logic [WIDTH_D:0]   prem_next;
    logic [WIDTH_N-1:0] work_next;
    logic [WIDTH_D-1:0] rem_mag;
    logic [WIDTH_N-1:0] quot_final;
    logic [WIDTH_D-1:0] rem_final;

    assign divisor_zero = (divisor == '0);
    assign is_ovf       = (dividend == {1'b1, {(WIDTH_N-1){1'b0}}}) && (divisor == '1);
    assign dividend_mag = dividend[WIDTH_N-1] ? -dividend : dividend;
    assign divisor_ext  = {divisor[WIDTH_D-1], divisor};
    assign divisor_mag  = divisor_ext[WIDTH_D] ? -divisor_ext : divisor_ext;

    // The partial remainder stays below |divisor|, so its top bit is always
    // free and the shifted value fits the same WIDTH_D+1 bit register.
    assign shifted    = {prem[WIDTH_D-1:0], work[WIDTH_N-1]};
    assign fits       = (shifted >= dsr_mag);
    assign prem_next  = fits ? (shifted - dsr_mag) : shifted;
    assign work_next  = {work[WIDTH_N-2:0], fits};
    assign rem_mag    = prem_next[WIDTH_D-1:0];
    assign quot_final = neg_q ? -work_next : work_next;
    assign rem_final  = neg_r ? -rem_mag : rem_mag;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the handshake outputs, which depend only on state
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (data_valid) begin
                    state_next = divisor_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, shift-subtract iteration and result registration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            work        <= '0;
            dsr_mag     <= '0;
            prem        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            ovf_pending <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_valid) begin
                        if (divisor_zero) begin
                            quotient    <= '1;
                            remainder   <= dividend[WIDTH_D-1:0];
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end else begin
                            work        <= dividend_mag;
                            dsr_mag     <= divisor_mag;
                            prem        <= '0;
                            count       <= CW'(WIDTH_N - 1);
                            neg_q       <= dividend[WIDTH_N-1] ^ divisor[WIDTH_D-1];
                            neg_r       <= dividend[WIDTH_N-1];
                            ovf_pending <= is_ovf;
                        end
                    end
                end
                CALC: begin
                    work  <= work_next;
                    prem  <= prem_next;
                    count <= count - CW'(1);
                    if (count == '0) begin
                        quotient    <= quot_final;
                        remainder   <= rem_final;
                        div_by_zero <= 1'b0;
                        overflow    <= ovf_pending;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed bench for seq_divider with a
// cycle-level reference model built from integer division.
module tb_seq_divider;

   localparam int N = 18;
   localparam int D = 8;

   logic         clk;
   logic         rst;
   logic         data_valid;
   logic         ready;
   logic [N-1:0] dividend;
   logic [D-1:0] divisor;
   logic [N-1:0] quotient;
   logic [D-1:0] remainder;
   logic         out_valid;
   logic         div_by_zero;
   logic         overflow;

   int errors;
   int checks;
   logic checkEn;

   // Reference model state: expected outputs and cycles left in the operation
   logic         expReady;
   logic         expValid;
   logic [N-1:0] expQ;
   logic [D-1:0] expR;
   logic         expDbz;
   logic         expOvf;
   int           remaining;
   logic [N-1:0] pendN;
   logic [D-1:0] pendD;

   seq_divider #(.WIDTH_N(N), .WIDTH_D(D)) dut (
      .clk(clk),
      .rst(rst),
      .data_valid(data_valid),
      .ready(ready),
      .dividend(dividend),
      .divisor(divisor),
      .quotient(quotient),
      .remainder(remainder),
      .out_valid(out_valid),
      .div_by_zero(div_by_zero),
      .overflow(overflow)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Plain integer division: truncation toward zero, remainder follows dividend
   function automatic logic [N-1:0] refQuot(logic [N-1:0] n, logic [D-1:0] d);
      longint sn;
      longint sd;
      longint q;
      sn = longint'($signed(n));
      sd = longint'($signed(d));
      if (sd == 0) return '1;
      q = sn / sd;
      return q[N-1:0];
   endfunction

   function automatic logic [D-1:0] refRem(logic [N-1:0] n, logic [D-1:0] d);
      longint sn;
      longint sd;
      longint r;
      sn = longint'($signed(n));
      sd = longint'($signed(d));
      if (sd == 0) return n[D-1:0];
      r = sn % sd;
      return r[D-1:0];
   endfunction

   function automatic logic refOvf(logic [N-1:0] n, logic [D-1:0] d);
      longint sn;
      longint sd;
      sn = longint'($signed(n));
      sd = longint'($signed(d));
      return (sd == -1) && (sn == -(longint'(1) << (N - 1)));
   endfunction

   // Timing model: results appear N edges after accept, or on the accept edge
   // for a zero divisor, then one pulse cycle before ready returns
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         expReady  <= 1'b1;
         expValid  <= 1'b0;
         expQ      <= '0;
         expR      <= '0;
         expDbz    <= 1'b0;
         expOvf    <= 1'b0;
         remaining <= 0;
         pendN     <= '0;
         pendD     <= '0;
      end else if (expReady) begin
         if (data_valid) begin
            expReady <= 1'b0;
            pendN    <= dividend;
            pendD    <= divisor;
            if (divisor == '0) begin
               expValid  <= 1'b1;
               expQ      <= refQuot(dividend, divisor);
               expR      <= refRem(dividend, divisor);
               expDbz    <= 1'b1;
               expOvf    <= 1'b0;
               remaining <= 0;
            end else begin
               remaining <= N;
            end
         end
      end else if (remaining > 0) begin
         remaining <= remaining - 1;
         if (remaining == 1) begin
            expValid <= 1'b1;
            expQ     <= refQuot(pendN, pendD);
            expR     <= refRem(pendN, pendD);
            expDbz   <= 1'b0;
            expOvf   <= refOvf(pendN, pendD);
         end
      end else begin
         expValid <= 1'b0;
         expReady <= 1'b1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (checkEn && !rst) begin
         checkOutput("cyc_ready", ready, expReady);
         checkOutput("cyc_out_valid", out_valid, expValid);
         checkOutput("cyc_quotient", quotient, expQ);
         checkOutput("cyc_remainder", remainder, expR);
         checkOutput("cyc_div_by_zero", div_by_zero, expDbz);
         checkOutput("cyc_overflow", overflow, expOvf);
      end
   end

   // Wait for ready, present one operation and return just after the accept edge
   task automatic applyStimulus(input logic [N-1:0] n, input logic [D-1:0] d);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("ready_wait", ready, 1);
      #1;
      dividend   = n;
      divisor    = d;
      data_valid = 1'b1;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
   endtask

   // Count edges after the accept edge until out_valid is observed
   task automatic waitResult(output int lat);
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      checkOutput("out_valid_seen", out_valid, 1);
   endtask

   task automatic runDirected(input string name, input logic [N-1:0] n, input logic [D-1:0] d,
                              input logic [N-1:0] q, input logic [D-1:0] r,
                              input logic dbz, input logic ovf, input int latExp);
      int lat;
      applyStimulus(n, d);
      waitResult(lat);
      checkOutput({name, "_q"}, quotient, q);
      checkOutput({name, "_r"}, remainder, r);
      checkOutput({name, "_dbz"}, div_by_zero, dbz);
      checkOutput({name, "_ovf"}, overflow, ovf);
      checkOutput({name, "_latency"}, lat, latExp);
      @(negedge clk);
      checkOutput({name, "_pulse"}, out_valid, 0);
   endtask

   // Hard stop in case something wedges the run
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [N-1:0] rn;
      logic [D-1:0] rd;
      logic [N-1:0] prod;
      int lat;
      errors     = 0;
      checks     = 0;
      checkEn    = 1'b0;
      rst        = 1'b1;
      data_valid = 1'b0;
      dividend   = '0;
      divisor    = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_ready", ready, 1);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_quotient", quotient, 0);
      checkOutput("reset_remainder", remainder, 0);
      checkOutput("reset_flags", {div_by_zero, overflow}, 0);
      @(negedge clk);
      #1;
      rst     = 1'b0;
      checkEn = 1'b1;

      $display("[TB] directed operations");
      runDirected("basic", 18'd1000, 8'd7, 18'd142, 8'd6, 1'b0, 1'b0, N);
      runDirected("neg_pos", -18'sd1000, 8'sd7, -18'sd142, -8'sd6, 1'b0, 1'b0, N);
      runDirected("pos_neg", 18'sd1000, -8'sd7, -18'sd142, 8'sd6, 1'b0, 1'b0, N);
      runDirected("neg_neg", -18'sd1000, -8'sd7, 18'sd142, -8'sd6, 1'b0, 1'b0, N);
      runDirected("zero_num", 18'd0, 8'd5, 18'd0, 8'd0, 1'b0, 1'b0, N);
      runDirected("div_zero", 18'h004D2, 8'h00, 18'h3FFFF, 8'hD2, 1'b1, 1'b0, 0);
      runDirected("after_dz", 18'd100, 8'd10, 18'd10, 8'd0, 1'b0, 1'b0, N);
      runDirected("ovf", 18'h20000, 8'hFF, 18'h20000, 8'h00, 1'b0, 1'b1, N);
      runDirected("min_div", 18'd5, 8'h80, 18'd0, 8'd5, 1'b0, 1'b0, N);
      runDirected("min_min", 18'h20000, 8'h80, 18'd1024, 8'd0, 1'b0, 1'b0, N);

      $display("[TB] randomized operations");
      for (int i = 0; i < 40; i++) begin
         rn = N'($urandom);
         rd = D'($urandom);
         case ($urandom_range(0, 9))
            0: rd = '0;
            1: rd = '1;
            2: rd = 8'h80;
            3: begin rn = 18'h20000; rd = '1; end
            default: ;
         endcase
         applyStimulus(rn, rd);
         waitResult(lat);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("[TB] data_valid held high with changing operands");
      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         #1;
         dividend   = N'($urandom);
         divisor    = D'($urandom);
         if ($urandom_range(0, 7) == 0) divisor = '0;
         data_valid = 1'b1;
      end
      @(negedge clk);
      #1;
      data_valid = 1'b0;

      $display("[TB] reset during an operation");
      applyStimulus(18'd5000, 8'd3);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("midrst_ready", ready, 1);
      checkOutput("midrst_out_valid", out_valid, 0);
      checkOutput("midrst_quotient", quotient, 0);
      checkOutput("midrst_remainder", remainder, 0);
      checkOutput("midrst_flags", {div_by_zero, overflow}, 0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      repeat (N + 4) @(negedge clk);

      prod = N'(-300 * 77);
      runDirected("round_trip", prod, 8'd77, -18'sd300, 8'd0, 1'b0, 1'b0, N);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
